// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ready handshake,
// and produces registered PC/instruction pairs for the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        inst_valid
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  stale_addr;
    logic [31:0]  hold_buf;
    logic [31:0]  pc_next;

    assign pc_next = pc + STEP;

    // Request is gated by rst so a late ready during reset is never seen as a completion.
    assign imem_req  = ~rst & (state != HOLD);
    // In DROP the in-flight request keeps its original address while pc already holds the target.
    assign imem_addr = (state == DROP) ? stale_addr : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            stale_addr      <= RESET_PC;
            hold_buf        <= NOP_INSTR;
            pc_out          <= 32'h0;
            instruction_out <= NOP_INSTR;
            inst_valid      <= 1'b0;
        end else if (branch_taken) begin
            instruction_out <= NOP_INSTR;
            inst_valid      <= 1'b0;
            pc              <= branch_addr;
            case (state)
                FETCH: if (!imem_ready) begin
                    stale_addr <= pc;
                    state      <= DROP;
                end
                HOLD:    state <= FETCH;
                DROP:    if (imem_ready) state <= FETCH;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (freeze) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            instruction_out <= imem_rdata;
                            pc_out          <= pc_next;
                            inst_valid      <= 1'b1;
                            pc              <= pc_next;
                        end
                    end else if (!freeze) begin
                        instruction_out <= NOP_INSTR;
                        inst_valid      <= 1'b0;
                    end
                end
                HOLD: if (!freeze) begin
                    instruction_out <= hold_buf;
                    pc_out          <= pc_next;
                    inst_valid      <= 1'b1;
                    pc              <= pc_next;
                    state           <= FETCH;
                end
                DROP: begin
                    if (imem_ready) state <= FETCH;
                    if (!freeze) begin
                        instruction_out <= NOP_INSTR;
                        inst_valid      <= 1'b0;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
